// File: rtl/pc_sequencer_if.sv
// Bundles the fetch port and the execute-side next-PC controls of the PC sequencer.
// The master modport is the sequencer; the slave modport is the memory/execute side.
interface pc_sequencer_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        instr_done;
    logic [1:0]  pc_sel;
    logic        branch_taken;
    logic [31:0] imm_value;
    logic [31:0] jalr_target;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        misalign;
    logic [31:0] bad_pc;
    logic        halted;
    logic [31:0] instret;

    modport master (
        output imem_req, imem_addr, pc, pc_plus4, misalign, bad_pc, halted, instret,
        input  imem_ready, instr_done, pc_sel, branch_taken, imm_value, jalr_target
    );

    modport slave (
        input  imem_req, imem_addr, pc, pc_plus4, misalign, bad_pc, halted, instret,
        output imem_ready, instr_done, pc_sel, branch_taken, imm_value, jalr_target
    );
endinterface

// File: rtl/pc_sequencer.sv
// Multicycle PC controller: one fetch per PC, wait for execute, then commit the next PC.
// Misaligned commit targets redirect to TRAP_PC and are latched in bad_pc.
//
// state    | meaning
// ST_FETCH | imem_req high, waiting for imem_ready
// ST_EXEC  | waiting for instr_done, commits next PC
// ST_HALT  | terminal after pc_sel=11 commit, left only by rst
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] TRAP_PC  = 32'h0000_0010
) (
    input  logic           clk,
    input  logic           rst,
    pc_sequencer_if.master bus
);
    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_HALT  = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instret_q, instret_d;
    logic [31:0] bad_pc_q, bad_pc_d;
    logic        misalign_q, misalign_d;
    logic [31:0] pc_add4, pc_addimm, target;

    assign pc_add4   = pc_q + 32'd4;
    assign pc_addimm = pc_q + bus.imm_value;

    always_comb begin
        target = pc_add4;
        case (bus.pc_sel)
            2'b00:   target = pc_add4;
            2'b01:   target = bus.branch_taken ? pc_addimm : pc_add4;
            2'b10:   target = {bus.jalr_target[31:1], 1'b0};
            default: target = pc_q;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instret_d  = instret_q;
        bad_pc_d   = bad_pc_q;
        misalign_d = 1'b0;
        case (state_q)
            ST_FETCH: begin
                if (bus.imem_ready) begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (bus.instr_done) begin
                    if (bus.pc_sel == 2'b11) begin
                        state_d = ST_HALT;
                    end else begin
                        state_d   = ST_FETCH;
                        instret_d = instret_q + 32'd1;
                        // A trapped commit still retires the instruction.
                        if (target[1:0] != 2'b00) begin
                            pc_d       = TRAP_PC;
                            bad_pc_d   = target;
                            misalign_d = 1'b1;
                        end else begin
                            pc_d = target;
                        end
                    end
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_FETCH;
            pc_q       <= RESET_PC;
            instret_q  <= 32'd0;
            bad_pc_q   <= 32'd0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instret_q  <= instret_d;
            bad_pc_q   <= bad_pc_d;
            misalign_q <= misalign_d;
        end
    end

    // rst masks the Moore outputs so nothing is requested while reset is held.
    assign bus.imem_req  = (state_q == ST_FETCH) && !rst;
    assign bus.halted    = (state_q == ST_HALT) && !rst;
    assign bus.imem_addr = pc_q;
    assign bus.pc        = pc_q;
    assign bus.pc_plus4  = pc_add4;
    assign bus.misalign  = misalign_q;
    assign bus.bad_pc    = bad_pc_q;
    assign bus.instret   = instret_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a reference model pushes expected post-commit state
// into a queue at stimulus time; it is popped and compared after the commit edge.
module tb_pc_sequencer;
    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam logic [31:0] TRP_PC = 32'h0000_0010;

    logic clk = 1'b0;
    logic rst = 1'b1;
    pc_sequencer_if bus ();

    pc_sequencer #(.RESET_PC(RST_PC), .TRAP_PC(TRP_PC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instret;
        logic [31:0] bad_pc;
        logic        misalign;
        logic        halted;
        logic        imem_req;
    } exp_t;

    exp_t        sb_q[$];
    int          npass = 0;
    int          ntotal = 0;
    logic [31:0] m_pc, m_instret, m_bad;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // One full instruction: optional fetch/exec wait states, then a commit.
    task automatic do_instr(input logic [1:0] sel, input logic taken, input logic [31:0] imm,
                            input logic [31:0] jt, input int fw, input int ew);
        logic [31:0] tgt;
        exp_t        e, o;
        chk("fetch_req", {31'd0, bus.imem_req}, 32'd1);
        chk("fetch_addr", bus.imem_addr, m_pc);
        chk("pc_plus4", bus.pc_plus4, m_pc + 32'd4);
        bus.imem_ready = 1'b0;
        for (int i = 0; i < fw; i++) begin
            cyc();
            chk("fwait_req", {31'd0, bus.imem_req}, 32'd1);
            chk("fwait_pc", bus.pc, m_pc);
        end
        bus.imem_ready = 1'b1;
        cyc();
        bus.imem_ready = 1'b0;
        chk("exec_req", {31'd0, bus.imem_req}, 32'd0);
        for (int i = 0; i < ew; i++) begin
            cyc();
            chk("ewait_pc", bus.pc, m_pc);
        end
        case (sel)
            2'b00:   tgt = m_pc + 32'd4;
            2'b01:   tgt = taken ? m_pc + imm : m_pc + 32'd4;
            2'b10:   tgt = jt & 32'hFFFF_FFFE;
            default: tgt = m_pc;
        endcase
        e.misalign = 1'b0;
        e.halted   = (sel == 2'b11);
        e.imem_req = (sel != 2'b11);
        if (sel != 2'b11) begin
            m_instret = m_instret + 32'd1;
            if (tgt[1:0] != 2'b00) begin
                m_pc       = TRP_PC;
                m_bad      = tgt;
                e.misalign = 1'b1;
            end else begin
                m_pc = tgt;
            end
        end
        e.pc = m_pc;
        e.instret = m_instret;
        e.bad_pc = m_bad;
        sb_q.push_back(e);
        bus.instr_done   = 1'b1;
        bus.pc_sel       = sel;
        bus.branch_taken = taken;
        bus.imm_value    = imm;
        bus.jalr_target  = jt;
        cyc();
        bus.instr_done   = 1'b0;
        bus.pc_sel       = 2'b11;
        bus.branch_taken = 1'b1;
        bus.imm_value    = 32'h0000_0001;
        bus.jalr_target  = 32'h0000_0003;
        o = sb_q.pop_front();
        chk("commit_pc", bus.pc, o.pc);
        chk("commit_instret", bus.instret, o.instret);
        chk("commit_bad_pc", bus.bad_pc, o.bad_pc);
        chk("commit_misalign", {31'd0, bus.misalign}, {31'd0, o.misalign});
        chk("commit_halted", {31'd0, bus.halted}, {31'd0, o.halted});
        chk("commit_req", {31'd0, bus.imem_req}, {31'd0, o.imem_req});
    endtask

    initial begin
        bus.imem_ready   = 1'b0;
        bus.instr_done   = 1'b0;
        bus.pc_sel       = 2'b00;
        bus.branch_taken = 1'b0;
        bus.imm_value    = 32'd0;
        bus.jalr_target  = 32'd0;
        m_pc = RST_PC;
        m_instret = 32'd0;
        m_bad = 32'd0;

        // Reset held for two edges, with noise on the handshake inputs.
        bus.imem_ready = 1'b1;
        bus.instr_done = 1'b1;
        cyc();
        cyc();
        chk("rst_pc", bus.pc, RST_PC);
        chk("rst_req", {31'd0, bus.imem_req}, 32'd0);
        chk("rst_instret", bus.instret, 32'd0);
        chk("rst_bad_pc", bus.bad_pc, 32'd0);
        chk("rst_misalign", {31'd0, bus.misalign}, 32'd0);
        chk("rst_halted", {31'd0, bus.halted}, 32'd0);
        bus.imem_ready = 1'b0;
        bus.instr_done = 1'b0;
        rst = 1'b0;
        #1;
        chk("post_rst_req", {31'd0, bus.imem_req}, 32'd1);
        chk("post_rst_addr", bus.imem_addr, RST_PC);

        // Sequential, zero wait states: 0x100 -> 0x104 -> 0x108 -> 0x10C.
        do_instr(2'b00, 1'b0, 32'd0, 32'd0, 0, 0);
        do_instr(2'b00, 1'b0, 32'd0, 32'd0, 0, 0);
        do_instr(2'b00, 1'b0, 32'd0, 32'd0, 0, 0);
        chk("instret_3", bus.instret, 32'd3);

        // Back to 0x108, then branch taken by -8 to 0x100.
        do_instr(2'b10, 1'b0, 32'd0, 32'h0000_0108, 0, 0);
        do_instr(2'b01, 1'b1, 32'hFFFF_FFF8, 32'd0, 0, 1);
        chk("br_taken_pc", bus.pc, 32'h0000_0100);

        // Not-taken branch at 0x108 with a 3-cycle fetch delay.
        do_instr(2'b10, 1'b0, 32'd0, 32'h0000_0108, 0, 0);
        do_instr(2'b01, 1'b0, 32'hFFFF_FFF8, 32'd0, 3, 2);
        chk("br_nt_pc", bus.pc, 32'h0000_010C);

        // JALR bit0 clear, then a misaligned JALR target.
        do_instr(2'b10, 1'b0, 32'd0, 32'h0000_0205, 0, 0);
        chk("jalr_pc", bus.pc, 32'h0000_0204);
        do_instr(2'b10, 1'b0, 32'd0, 32'h0000_0203, 0, 0);
        cyc();
        chk("misalign_clear", {31'd0, bus.misalign}, 32'd0);
        chk("trap_pc_hold", bus.pc, TRP_PC);
        chk("bad_pc_hold", bus.bad_pc, 32'h0000_0202);

        // Wrap: 0xFFFF_FFFC + 4 = 0, then a taken branch to a misaligned pc+imm.
        do_instr(2'b10, 1'b0, 32'd0, 32'hFFFF_FFFC, 0, 0);
        do_instr(2'b00, 1'b0, 32'd0, 32'd0, 1, 0);
        chk("wrap_pc", bus.pc, 32'h0000_0000);
        do_instr(2'b01, 1'b1, 32'h0000_0002, 32'd0, 0, 0);

        // Halt at 0x120, then pulse handshakes that must be ignored.
        do_instr(2'b10, 1'b0, 32'd0, 32'h0000_0120, 0, 0);
        do_instr(2'b11, 1'b0, 32'd0, 32'd0, 0, 0);
        bus.imem_ready = 1'b1;
        bus.instr_done = 1'b1;
        bus.pc_sel     = 2'b00;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("halt_halted", {31'd0, bus.halted}, 32'd1);
            chk("halt_req", {31'd0, bus.imem_req}, 32'd0);
            chk("halt_pc", bus.pc, 32'h0000_0120);
            chk("halt_instret", bus.instret, m_instret);
        end
        bus.imem_ready = 1'b0;
        bus.instr_done = 1'b0;

        // Reset recovers from HALT.
        rst = 1'b1;
        cyc();
        chk("halt_rst_halted", {31'd0, bus.halted}, 32'd0);
        rst = 1'b0;
        #1;
        m_pc = RST_PC;
        m_instret = 32'd0;
        m_bad = 32'd0;
        chk("recover_pc", bus.pc, RST_PC);
        chk("recover_req", {31'd0, bus.imem_req}, 32'd1);
        chk("recover_instret", bus.instret, 32'd0);

        // rst wins over a same-cycle commit of a taken branch.
        do_instr(2'b00, 1'b0, 32'd0, 32'd0, 0, 0);
        bus.imem_ready = 1'b1;
        cyc();
        bus.imem_ready   = 1'b0;
        bus.instr_done   = 1'b1;
        bus.pc_sel       = 2'b01;
        bus.branch_taken = 1'b1;
        bus.imm_value    = 32'h0000_0040;
        rst = 1'b1;
        cyc();
        bus.instr_done = 1'b0;
        rst = 1'b0;
        #1;
        chk("rst_commit_pc", bus.pc, RST_PC);
        chk("rst_commit_instret", bus.instret, 32'd0);
        chk("rst_commit_req", {31'd0, bus.imem_req}, 32'd1);
        m_pc = RST_PC;
        m_instret = 32'd0;
        do_instr(2'b00, 1'b0, 32'd0, 32'd0, 0, 0);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end
endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Multicycle program-counter controller for the RV32I core. Owns the architectural PC register and sequences the `pc_add4` / `pc_addimm` adders: it issues one instruction fetch per PC, waits for execute to finish, then commits the next PC. Next-PC sources are sequential, branch/JAL, or JALR. Misaligned targets redirect to a trap vector. The block sits between the instruction-memory port and the execute/decode stage.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset.
- `TRAP_PC`, default 32'h0000_0010: PC loaded when a committed target is misaligned.

- `clk` in 1: single clock, all state updates on rising edge.
- `rst` in 1: reset is synchronous and active-high.
- `imem_req` out 1: fetch request, high in FETCH state only.
- `imem_addr` out 32: fetch address, equals `pc`.
- `imem_ready` in 1: memory accepts/returns fetch this cycle.
- `instr_done` in 1: execute finished current instruction; next-PC inputs valid this cycle.
- `pc_sel` in 2: 00 sequential, 01 branch/JAL, 10 JALR, 11 halt.
- `branch_taken` in 1: for `pc_sel`=01; JAL drives 1.
- `imm_value` in 32: sign-extended immediate for pc+imm.
- `jalr_target` in 32: rs1+imm from ALU.
- `pc` out 32: current PC register.
- `pc_plus4` out 32: pc+4 (combinational, link value).
- `misalign` out 1: one-cycle pulse after a trapped commit.
- `bad_pc` out 32: last misaligned target; holds until next trap or reset.
- `halted` out 1: high in HALT state.
- `instret` out 32: retired-instruction counter.

## Operation
- Adders: one `pc_add4` (pc → pc_plus4) and one `pc_addimm` (pc, imm_value → pc+imm), both combinational from the current `pc`. Carries discarded; arithmetic is mod 2^32 (0xFFFF_FFFC+4 = 0x0).
- States:
  - FETCH: `imem_req`=1. If `imem_ready`=1, go to EXEC. Otherwise stay.
  - EXEC: `imem_req`=0. If `instr_done`=1, commit and go to FETCH, or to HALT if `pc_sel`=11. Otherwise stay.
  - HALT: terminal until `rst`.
- Target on commit:
  - 00: pc_plus4.
  - 01: pc+imm if `branch_taken`, else pc_plus4.
  - 10: `jalr_target` with bit0 cleared.
  - 11: pc unchanged.
- Misalign check: if target[1:0] != 0 (after JALR bit0 clear), then `pc`←TRAP_PC, `bad_pc`←target, and `misalign` pulses in the next cycle. The instruction still counts as retired.
- `instret` increments on every commit with `pc_sel` != 11. Wraps 0xFFFF_FFFF→0.
- Ignored inputs:
  - `instr_done` in FETCH and HALT.
  - `imem_ready` in EXEC and HALT.
  - `pc_sel`, `branch_taken`, `imm_value`, `jalr_target` except in the commit cycle.

## Timing
- Reset (`rst`=1 at an edge) sets:
  - state FETCH, `pc`=RESET_PC, `instret`=0, `bad_pc`=0, `misalign`=0.
  - While `rst` is high, `imem_req` and `halted` are forced to 0.
- First cycle after `rst` falls: `imem_req`=1, `imem_addr`=RESET_PC.
- `imem_req`, `halted`, `misalign` are registered/Moore outputs. `pc_plus4` is combinational from `pc`.
- Minimum 2 cycles per instruction: ready in FETCH cycle N, done in EXEC cycle N+1, new `pc` visible and `imem_req`=1 at N+2.
- Wait states in either state extend the instruction with no change to `pc`.
- `rst` has priority over every event, including a same-cycle `instr_done`: no commit, `instret` not incremented.
- Reset mid-EXEC abandons the instruction.

## Test plan
- Reset, RESET_PC=0x100: hold `rst` 2 cycles → `pc`=0x100, `imem_req`=0, `instret`=0. First cycle after release → `imem_req`=1, `imem_addr`=0x100.
- Sequential with zero wait states: `imem_ready` and `instr_done` asserted each opportunity, `pc_sel`=00 → `pc` 0x100, 0x104, 0x108, each held 2 cycles; `instret`=3 after third commit. Separate run from 0xFFFF_FFFC → `pc`=0x0.
- Branch at `pc`=0x108, `imm_value`=0xFFFF_FFF8:
  - `branch_taken`=1 → `pc`=0x100.
  - Repeat with `branch_taken`=0 → 0x10C.
  - 3-cycle `imem_ready` delay → `pc` stable, `imem_req` held high.
- JALR alignment:
  - `jalr_target`=0x205 → `pc`=0x204, no `misalign`.
  - `jalr_target`=0x203 → `pc`=TRAP_PC (0x10), `bad_pc`=0x202, `misalign` high exactly 1 cycle, `instret` incremented.
- Halt: commit with `pc_sel`=11 at `pc`=0x120 → `halted`=1, `pc`=0x120, `imem_req`=0 forever, `instret` unchanged. Further `instr_done`/`imem_ready` pulses have no effect. `rst` recovers to FETCH at RESET_PC.
- `rst` and `instr_done` (`pc_sel`=01, taken) in the same EXEC cycle → `pc`=RESET_PC, `instret`=0, state FETCH.
